// File: rtl/counter_pkg.sv
//==============================================================================
// counter_pkg : shared constants and helpers for the modulo-N counter | rev 1.0
//==============================================================================
`default_nettype none

package counter_pkg;

  localparam int COUNTER_DEFAULT_WIDTH = 4;

  // Terminal value MODULO-1; callers cast the result down to their WIDTH.
  function automatic logic [31:0] counter_term(input longint unsigned modulo);
    return 32'(modulo - 64'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/counter.sv
//==============================================================================
// counter : free-running modulo-N up-counter with terminal-count flag | rev 1.0
//==============================================================================
`default_nettype none

module counter
  import counter_pkg::*;
#(
  parameter int              WIDTH  = COUNTER_DEFAULT_WIDTH,
  parameter longint unsigned MODULO = 64'd1 << WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  localparam logic [WIDTH-1:0] TERM = WIDTH'(counter_term(MODULO));
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  if ((WIDTH < 1) || (WIDTH > 32) || (MODULO < 64'd2) ||
      (MODULO > (64'd1 << WIDTH))) begin : g_bad_params
    $fatal(1, "counter: illegal WIDTH/MODULO combination");
  end

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             at_term;

  assign at_term = (count_q == TERM);

  // Explicit wrap so a short modulus never relies on natural overflow.
  always_comb begin
    count_d = count_q + ONE;
    if (at_term) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tc    = at_term;

  a_in_range: assert property (@(posedge clk) disable iff (rst)
    (64'(count_q) < MODULO));

endmodule

`default_nettype wire

// File: tb/tb_counter.sv
//==============================================================================
// tb_counter : self-checking bench for counter across several configurations | rev 1.0
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_counter;

  logic       clk;
  logic       rst;
  logic [3:0] w_cnt_def;
  logic       w_tc_def;
  logic [3:0] w_cnt_m10;
  logic       w_tc_m10;
  logic [0:0] w_cnt_w1;
  logic       w_tc_w1;
  logic [7:0] w_cnt_w8;
  logic       w_tc_w8;

  int checks   = 0;
  int failures = 0;
  int edges    = 0;
  int tc_hits  = 0;

  counter u_def (.clk(clk), .rst(rst), .count(w_cnt_def), .tc(w_tc_def));

  counter #(.WIDTH(4), .MODULO(64'd10)) u_m10 (
    .clk(clk), .rst(rst), .count(w_cnt_m10), .tc(w_tc_m10));

  counter #(.WIDTH(1), .MODULO(64'd2)) u_w1 (
    .clk(clk), .rst(rst), .count(w_cnt_w1), .tc(w_tc_w1));

  counter #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .count(w_cnt_w8), .tc(w_tc_w8));

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: after reset, the value is simply the number of qualifying edges mod N.
  always @(posedge clk or posedge rst) begin
    if (rst) edges <= 0;
    else     edges <= edges + 1;
  end

  always @(negedge clk) begin
    chk("def_count", w_cnt_def, edges % 16);
    chk("def_tc",    w_tc_def,  (edges % 16) == 15);
    chk("m10_count", w_cnt_m10, edges % 10);
    chk("m10_tc",    w_tc_m10,  (edges % 10) == 9);
    chk("m10_range", w_cnt_m10 < 4'd10, 1);
    chk("w1_count",  w_cnt_w1,  edges % 2);
    chk("w1_tc",     w_tc_w1,   (edges % 2) == 1);
    chk("w8_count",  w_cnt_w8,  edges % 256);
    chk("w8_tc",     w_tc_w8,   (edges % 256) == 255);
    if (w_tc_def && !rst) tc_hits++;
  end

  initial begin
    rst = 1'b1;
    #1;
    chk("por_count", w_cnt_def, 0);
    chk("por_tc",    w_tc_def,  0);
    #104;
    chk("rst_hold_count", w_cnt_def, 0);
    chk("rst_hold_tc",    w_tc_def,  0);
    chk("rst_hold_w8",    w_cnt_w8,  0);
    #5 rst = 1'b0;

    @(posedge clk); #1;
    chk("first_edge", w_cnt_def, 1);
    @(posedge clk); #1;
    chk("second_edge", w_cnt_def, 2);

    repeat (13) @(posedge clk);
    #1;
    chk("def_at_15",    w_cnt_def, 15);
    chk("def_tc_at_15", w_tc_def,  1);
    chk("m10_at_5",     w_cnt_m10, 5);
    @(posedge clk); #1;
    chk("def_wrap",    w_cnt_def, 0);
    chk("def_wrap_tc", w_tc_def,  0);

    repeat (3) @(posedge clk);
    #1;
    chk("m10_at_9",    w_cnt_m10, 9);
    chk("m10_tc_at_9", w_tc_m10,  1);
    @(posedge clk); #1;
    chk("m10_wrap",    w_cnt_m10, 0);
    chk("m10_wrap_tc", w_tc_m10,  0);

    @(posedge clk); #1;
    chk("w1_one", w_cnt_w1, 1);
    chk("w1_tc",  w_tc_w1,  1);
    @(posedge clk); #1;
    chk("w1_zero", w_cnt_w1, 0);

    // 247 edges by 10 us: tc seen at n = 15, 31, ..., 239.
    #(64'd10010 - $time);
    chk("tc_period_hits", tc_hits, 15);
    chk("pre_pulse_def",  w_cnt_def, 7);

    #2 rst = 1'b1;
    #1;
    chk("async_def",    w_cnt_def, 0);
    chk("async_def_tc", w_tc_def,  0);
    chk("async_m10",    w_cnt_m10, 0);
    chk("async_w8",     w_cnt_w8,  0);
    #4 rst = 1'b0;
    @(posedge clk); #1;
    chk("restart_def", w_cnt_def, 1);
    chk("restart_w8",  w_cnt_w8,  1);

    repeat (254) @(posedge clk);
    #1;
    chk("w8_at_255",    w_cnt_w8, 255);
    chk("w8_tc_at_255", w_tc_w8,  1);
    @(posedge clk); #1;
    chk("w8_wrap",    w_cnt_w8, 0);
    chk("w8_wrap_tc", w_tc_w8,  0);

    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/counter.md
Name: counter

Overview:
- Free-running synchronous up-counter with a parameterizable width and modulus.
- Increments once per rising clock edge and wraps to zero after its terminal value.
- Provides a basic timebase or sequence index for datapath and control blocks, and doubles as a bring-up smoke-test block.
- No enable or load inputs; after reset it counts continuously.

Parameters:
- WIDTH, 4, bit width of count; legal range 1..32.
- MODULO, 2**WIDTH (16), count sequence length; count runs 0..MODULO-1 then wraps; legal range 2..2**WIDTH.

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- count  output  WIDTH  current count value, driven directly from a register.
- tc  output  1  terminal-count flag; high while count == MODULO-1. May be left unconnected.

Behaviour:
- Reset:
  - While rst=1, count=0 and tc=0 (tc=1 only in the degenerate MODULO=1 case, which is disallowed).
  - Assertion takes effect immediately, with no clock edge needed.
  - Deassertion is sampled by the next rising clk edge.
  - Reset has priority over counting.
- Counting:
  - On each rising clk edge with rst=0: if count == MODULO-1 then count <= 0, else count <= count+1.
  - Latency: count changes exactly one edge after each qualifying edge. The first edge after rst falls yields count=1.
- Terminal count: tc is combinational from the count register (count == MODULO-1). It is high for exactly one clock period out of every MODULO cycles.
- Wrap-around:
  - Default config: 15 -> 0, with no overflow state and no X.
  - Non-power-of-two MODULO (e.g. 10): 9 -> 0. Values >= MODULO are never reached.
- Reset mid-operation: rst rising at any count value forces count=0 asynchronously. Counting resumes from 0 as above after release.
- Arithmetic: unsigned, WIDTH bits. The increment must not depend on natural overflow when MODULO < 2**WIDTH.
- No multi-driven signals. No latches. Outputs are never X after the first reset.
- Parameter checks: elaboration-time assertion that MODULO is in 2..2**WIDTH and WIDTH is in 1..32. Failure aborts elaboration.

Decomposition:
- Shared package (counter_pkg):
  - COUNTER_DEFAULT_WIDTH = 4.
  - Helper function returning the terminal value MODULO-1 sized to WIDTH.
- No sub-module; the block is a single register plus comparator. An optional assertion/cover bind module (counter_sva) holds the properties below for reuse by verification:
  - count < MODULO always.
  - count increments by 1 or wraps to 0 when out of reset.
  - tc iff count == MODULO-1.

Test Plan:
- Power-up reset: clk period 40 ns starting low, rst=1 from t=0 to t=110 ns -> count=0 and tc=0 throughout reset, including across clock edges at 20/60/100 ns.
- Release and count: rst falls at 110 ns -> first edge at 140 ns gives count=1, edge at 180 ns gives 2. count increases by exactly 1 per edge.
- Wrap (defaults): after 15 edges post-release -> count=15 with tc=1. Next edge -> count=0 with tc=0. Run to 10 us and check 16-cycle periodicity: tc high exactly once per 16 edges.
- Asynchronous mid-run reset: pulse rst=1 for 5 ns between edges while count=7 -> count=0 immediately, before the next edge. After release the sequence restarts at 1.
- Non-power-of-two modulus: WIDTH=4, MODULO=10 -> sequence 0..9 repeats, 9 -> 0, tc high at 9. Values 10..15 are never observed.
- Width extremes: WIDTH=1 (MODULO=2) toggles 0,1,0. WIDTH=8 wraps 255 -> 0 with tc at 255.
